hiscore_ram_arbiter: RTL and testbench

Arbitrates the game work-RAM port between the arcade CPU and the hiscore engine. When the hiscore engine signals read or write intent, the block stalls the CPU and lets in-flight CPU cycles drain. It then hands the RAM port to the hiscore engine and returns ownership to the CPU when intent drops. It sits between the game core's RAM and the hiscore module, alongside the pause controller, in the `clk_sys` domain.

---
 rtl/hiscore_pkg.sv | 5 +
 rtl/arb_down_counter.sv | 25 ++
 rtl/hiscore_ram_arbiter.sv | 123 ++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_pkg.sv
// Shared types for the hiscore RAM arbiter: ownership states and the default settle length.
package hiscore_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, GRANT, RELEASE} arb_state_t;
  localparam int HS_SETTLE_DEFAULT = 3;
endpackage

// File: rtl/arb_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero. Used for settle and watchdog timing.
module arb_down_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                  cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM port arbiter between the arcade CPU and the hiscore engine.
// Define HS_ARB_WATCHDOG_EN to build the hiscore-ownership watchdog and hs_timeout port.
module hiscore_ram_arbiter
  import hiscore_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int SETTLE = HS_SETTLE_DEFAULT
`ifdef HS_ARB_WATCHDOG_EN
  , parameter int HOLD_MAX = 4096
`endif
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_dout,
  input  logic          cpu_paused,
  output logic          cpu_wait,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write_enable,
  input  logic          hs_read_intent,
  input  logic          hs_write_intent,
  output logic [DW-1:0] hs_data_out,
  output logic          hs_grant,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
`ifdef HS_ARB_WATCHDOG_EN
  output logic          hs_timeout,
`endif
  input  logic [DW-1:0] ram_dout
);
  arb_state_t    state_q, state_d;
  logic          req, go, settle_zero, wd_fire, rd_q;
  logic [DW-1:0] hs_dout_q;

  assign req = hs_read_intent | hs_write_intent;

  arb_down_counter #(.W(4)) u_settle (
    .clk_i(clk_sys), .rst_i(reset),
    .load_i(state_q == IDLE), .load_val_i(4'(SETTLE - 1)),
    .dec_i(state_q == DRAIN), .zero_o(settle_zero)
  );

`ifdef HS_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(HOLD_MAX) + 1;
  logic wd_zero, blk_q, tmo_q;

  arb_down_counter #(.W(WD_W)) u_wd (
    .clk_i(clk_sys), .rst_i(reset),
    .load_i(state_q != GRANT), .load_val_i(WD_W'(HOLD_MAX - 1)),
    .dec_i(state_q == GRANT), .zero_o(wd_zero)
  );

  assign wd_fire = (state_q == GRANT) && req && wd_zero;
  // After a forced release, req must be seen low once before another grant.
  assign go      = req & ~blk_q;

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      blk_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      blk_q <= wd_fire | (blk_q & req);
      tmo_q <= tmo_q | wd_fire;
    end

  assign hs_timeout = tmo_q;
`else
  assign wd_fire = 1'b0;
  assign go      = req;
`endif

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = cpu_paused ? GRANT : DRAIN;
      DRAIN:   if (!req) state_d = RELEASE;
               else if (settle_zero) state_d = GRANT;
      GRANT:   if (!req || wd_fire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DRAIN keeps the CPU on the port so its last cycle completes; RELEASE blocks all writes.
  always_comb begin
    hs_grant = (state_q == GRANT);
    cpu_wait = (state_q != IDLE);
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = 1'b0;
    case (state_q)
      IDLE, DRAIN: ram_we = cpu_we & ~reset;
      GRANT: begin
        ram_addr = hs_address;
        ram_din  = hs_data_in;
        ram_we   = hs_write_enable;
      end
      default: ;
    endcase
  end

  // rd_q marks the cycle in which the RAM returns data for a GRANT-cycle address.
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      rd_q      <= 1'b0;
      hs_dout_q <= '0;
    end else begin
      rd_q <= (state_q == GRANT);
      if (rd_q) hs_dout_q <= ram_dout;
    end

  assign hs_data_out = hs_dout_q;
  assign cpu_dout    = ram_dout;
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Self-checking bench for hiscore_ram_arbiter: directed scenarios plus random traffic vs. a phase model.
module tb_hiscore_ram_arbiter;
  localparam int AW = 16, DW = 8, SETTLE = 3, HOLD = 16;
  localparam int P_CPU = 0, P_DRAIN = 1, P_HS = 2, P_REL = 3;

  logic          clk_sys = 1'b0, reset;
  logic [AW-1:0] cpu_addr, hs_address, ram_addr;
  logic [DW-1:0] cpu_din, cpu_dout, hs_data_in, hs_data_out, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          cpu_we, cpu_paused, cpu_wait, hs_write_enable, hs_read_intent, hs_write_intent;
  logic          hs_grant, ram_we;
`ifdef HS_ARB_WATCHDOG_EN
  logic          hs_timeout;
`endif

  int n_chk = 0, n_err = 0;

  always #5 clk_sys = ~clk_sys;

  hiscore_ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE)
`ifdef HS_ARB_WATCHDOG_EN
    , .HOLD_MAX(HOLD)
`endif
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .cpu_paused(cpu_paused), .cpu_wait(cpu_wait),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write_enable(hs_write_enable),
    .hs_read_intent(hs_read_intent), .hs_write_intent(hs_write_intent),
    .hs_data_out(hs_data_out), .hs_grant(hs_grant),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
`ifdef HS_ARB_WATCHDOG_EN
    .hs_timeout(hs_timeout),
`endif
    .ram_dout(ram_dout)
  );

  // Synchronous work RAM, read-before-write, one cycle latency.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference model: who owns the port, how long, and what the RAM should hold.
  int            ph = P_CPU, waited = 0, held = 0;
  bit            blocked = 0, m_tmo = 0, prev_hs = 0;
  logic [DW-1:0] shadow [0:65535];
  logic [DW-1:0] m_rdout = '0, m_hsdout = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_we();
    if (reset) return 1'b0;
    if (ph == P_HS) return hs_write_enable;
    if (ph == P_CPU || ph == P_DRAIN) return cpu_we;
    return 1'b0;
  endfunction

  task automatic model_edge();
    logic [AW-1:0] a;
    logic [DW-1:0] d, old;
    logic          w;
    bit            r;
    r   = hs_read_intent | hs_write_intent;
    a   = (ph == P_HS) ? hs_address : cpu_addr;
    d   = (ph == P_HS) ? hs_data_in : cpu_din;
    w   = exp_we();
    old = m_rdout;
    m_rdout = shadow[a];
    if (w) shadow[a] = d;
    if (reset) begin
      ph = P_CPU; m_hsdout = '0; prev_hs = 0; blocked = 0; m_tmo = 0;
    end else begin
      if (prev_hs) m_hsdout = old;
      prev_hs = (ph == P_HS);
      case (ph)
        P_CPU:   if (r && !blocked) begin
                   ph = cpu_paused ? P_HS : P_DRAIN; waited = 0; held = 0;
                 end
        P_DRAIN: if (!r) ph = P_REL;
                 else begin
                   waited++;
                   if (waited == SETTLE) begin ph = P_HS; held = 0; end
                 end
        P_HS: begin
          held++;
          if (!r) ph = P_REL;
`ifdef HS_ARB_WATCHDOG_EN
          else if (held == HOLD) begin ph = P_REL; m_tmo = 1; blocked = 1; end
`endif
        end
        default: ph = P_CPU;
      endcase
`ifdef HS_ARB_WATCHDOG_EN
      if (!r) blocked = 0;
`endif
    end
  endtask

  task automatic check_outputs();
    chk("hs_grant", hs_grant, ph == P_HS);
    chk("cpu_wait", cpu_wait, ph != P_CPU);
    chk("ram_we", ram_we, exp_we());
    chk("ram_addr", ram_addr, (ph == P_HS) ? hs_address : cpu_addr);
    if (exp_we()) chk("ram_din", ram_din, (ph == P_HS) ? hs_data_in : cpu_din);
    chk("cpu_dout", cpu_dout, m_rdout);
    chk("hs_data_out", hs_data_out, m_hsdout);
`ifdef HS_ARB_WATCHDOG_EN
    chk("hs_timeout", hs_timeout, m_tmo);
`endif
  endtask

  // Inputs are set just after a rising edge; check mid-cycle, then advance across the next edge.
  task automatic tick();
    #4 check_outputs();
    @(posedge clk_sys);
    model_edge();
    #1;
  endtask

  task automatic reset_mid();
    #3 reset = 1'b1;
    ph = P_CPU; m_hsdout = '0; prev_hs = 0; blocked = 0; m_tmo = 0;
    #1;
    chk("rst_grant", hs_grant, 1'b0);
    chk("rst_wait", cpu_wait, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_hsdout", hs_data_out, '0);
    @(posedge clk_sys);
    model_edge();
    #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; shadow[i] = '0; end
    reset = 1'b1; cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0; cpu_paused = 1'b0;
    hs_address = '0; hs_data_in = '0; hs_write_enable = 1'b0;
    hs_read_intent = 1'b0; hs_write_intent = 1'b0;
    #1;
    chk("reset_grant", hs_grant, 1'b0);
    chk("reset_wait", cpu_wait, 1'b0);
    chk("reset_we", ram_we, 1'b0);
    chk("reset_hsdout", hs_data_out, '0);
    repeat (2) begin @(posedge clk_sys); model_edge(); end
    #1 reset = 1'b0;

    // CPU pass-through write then read.
    cpu_addr = 16'h6010; cpu_din = 8'h5A; cpu_we = 1'b1; tick();
    cpu_we = 1'b0; tick();
    chk("passthru_rd", cpu_dout, 8'h5A);
    chk("passthru_wait", cpu_wait, 1'b0);

    // Drain then grant; a hiscore write during DRAIN must be dropped.
    hs_address = 16'h6010; hs_data_in = 8'hFF; hs_read_intent = 1'b1; n = 0;
    do begin
      tick(); n++;
      if (n == 1) chk("drain_wait", cpu_wait, 1'b1);
      hs_write_enable = !hs_grant;
    end while (!hs_grant && n < 20);
    chk("grant_latency", n, SETTLE + 1);
    tick(); tick();
    chk("hs_read", hs_data_out, 8'h5A);
    hs_write_enable = 1'b1; tick();
    hs_write_enable = 1'b0; tick();
    chk("hs_write", cpu_dout, 8'hFF);
    hs_read_intent = 1'b0; tick(); tick();

    // Already paused: one-cycle grant, two-cycle release.
    cpu_paused = 1'b1; hs_write_intent = 1'b1; tick();
    chk("paused_grant", hs_grant, 1'b1);
    hs_write_intent = 1'b0; tick();
    chk("release_wait1", cpu_wait, 1'b1);
    tick();
    chk("release_wait2", cpu_wait, 1'b0);

    // Asynchronous reset while granted with a write pending.
    hs_read_intent = 1'b1; tick();
    chk("pre_reset_grant", hs_grant, 1'b1);
    hs_write_enable = 1'b1; hs_data_in = 8'h33;
    reset_mid();
    hs_read_intent = 1'b0; hs_write_enable = 1'b0; tick();

`ifdef HS_ARB_WATCHDOG_EN
    hs_read_intent = 1'b1; tick();
    n = 0;
    while (hs_grant && n < 100) begin tick(); n++; end
    chk("wd_hold", n, HOLD);
    chk("wd_flag", hs_timeout, 1'b1);
    repeat (4) tick();
    chk("wd_no_regrant", hs_grant, 1'b0);
    hs_read_intent = 1'b0; tick();
    hs_read_intent = 1'b1; tick();
    chk("wd_regrant", hs_grant, 1'b1);
    hs_read_intent = 1'b0; tick(); tick();
`endif

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(7) == 0)  hs_read_intent  = ~hs_read_intent;
      if ($urandom_range(15) == 0) hs_write_intent = ~hs_write_intent;
      if ($urandom_range(5) == 0)  cpu_paused      = ~cpu_paused;
      cpu_we          = ($urandom_range(2) == 0);
      cpu_addr        = 16'h6010 + 16'($urandom_range(7));
      cpu_din         = 8'($urandom);
      hs_address      = 16'h6010 + 16'($urandom_range(7));
      hs_data_in      = 8'($urandom);
      hs_write_enable = 1'($urandom_range(1));
      if ($urandom_range(249) == 0) reset_mid();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
